// File: rtl/aes128_pkg.sv
// Shared AES-128 key-schedule primitives: S-box, Rcon, FSM state type and round count.
package aes128_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        INV  = 2'd2
    } fsm_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant lives in the top byte; indices outside 1..10 give zero.
    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

endpackage

// File: rtl/aes128_inv_key_expansion_if.sv
// Control/data bundle between a decryption datapath and the inverse key expander.
interface aes128_inv_key_expansion_if;
    import aes128_pkg::*;

    // key_load and rkey_en are single-cycle strobes sampled on the rising clk_sys edge with
    // no back-pressure; round_key_out/round_num_out are only meaningful while key_ready is 1.
    logic         key_load;
    logic [127:0] cipher_key;
    logic         rkey_en;
    logic [127:0] round_key_out;
    logic [3:0]   round_num_out;
    logic         key_ready;
    logic         busy;
    fsm_state_t   state_dbg;

    modport master (
        output key_load, cipher_key, rkey_en,
        input  round_key_out, round_num_out, key_ready, busy, state_dbg
    );

    modport slave (
        input  key_load, cipher_key, rkey_en,
        output round_key_out, round_num_out, key_ready, busy, state_dbg
    );

endinterface

// File: rtl/aes128_key_round.sv
// One AES-128 key-schedule step, forward (K(r-1)->K(r)) or inverse (K(r)->K(r-1)).
module aes128_key_round
    import aes128_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [3:0]   rnd,
    input  logic         inv,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] i1, i2, i3;
    logic [31:0] sub_in, t;
    logic [31:0] n0, f1, f2, f3;

    assign {w0, w1, w2, w3} = key_in;

    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;

    // The inverse step feeds the recovered w3 through the same SubWord/RotWord path,
    // so a single S-box bank serves both directions and w0 has the same form in both.
    assign sub_in = inv ? i3 : w3;
    assign t      = sub_word({sub_in[23:0], sub_in[31:24]}) ^ rcon(rnd);
    assign n0     = w0 ^ t;

    assign f1 = w1 ^ n0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign key_out = inv ? {n0, i1, i2, i3} : {n0, f1, f2, f3};

endmodule

// File: rtl/aes128_inv_key_expansion.sv
// AES-128 decryption key scheduler: pre-expands to K10, then steps down to K0 on rkey_en.
// Optional K10 cache enabled by defining AES128_INV_KEY_CACHE_EN.
module aes128_inv_key_expansion
    import aes128_pkg::*;
(
    input  logic clk_sys,
    input  logic rst_n,
    aes128_inv_key_expansion_if.slave kif
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    fsm_state_t   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         ready_q, ready_d;

    logic [3:0]   step_rnd;
    logic [127:0] step_key;
    logic         cache_hit;
    logic [127:0] cache_k10_q;

    // FWD builds K(r) with r = rnd+1; INV recovers K(r-1) using Rcon of the current r.
    assign step_rnd = (state_q == FWD) ? rnd_q + 4'd1 : rnd_q;

    aes128_key_round u_round (
        .key_in  (key_q),
        .rnd     (step_rnd),
        .inv     (state_q == INV),
        .key_out (step_key)
    );

`ifdef AES128_INV_KEY_CACHE_EN
    logic [127:0] load_key_q;
    logic [127:0] cache_key_q;
    logic         cache_vld_q;
    logic         fwd_done;

    assign cache_hit = cache_vld_q && (kif.cipher_key == cache_key_q);
    assign fwd_done  = (state_q == FWD) && (rnd_q == LAST_RND - 4'd1) && !kif.key_load;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            load_key_q  <= '0;
            cache_key_q <= '0;
            cache_k10_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            if (kif.key_load && !cache_hit)
                load_key_q <= kif.cipher_key;
            if (fwd_done) begin
                cache_key_q <= load_key_q;
                cache_k10_q <= step_key;
                cache_vld_q <= 1'b1;
            end
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_k10_q = '0;
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        ready_d = ready_q;
        if (kif.key_load) begin
            if (cache_hit) begin
                state_d = INV;
                key_d   = cache_k10_q;
                rnd_d   = LAST_RND;
                ready_d = 1'b1;
            end else begin
                state_d = FWD;
                key_d   = kif.cipher_key;
                rnd_d   = 4'd0;
                ready_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                FWD: begin
                    key_d = step_key;
                    rnd_d = step_rnd;
                    if (rnd_q == LAST_RND - 4'd1) begin
                        state_d = INV;
                        ready_d = 1'b1;
                    end
                end
                INV: begin
                    if (kif.rkey_en && rnd_q != 4'd0) begin
                        key_d = step_key;
                        rnd_d = rnd_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rnd_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            ready_q <= ready_d;
        end
    end

    assign kif.round_key_out = key_q;
    assign kif.round_num_out = rnd_q;
    assign kif.key_ready     = ready_q;
    assign kif.busy          = (state_q == FWD);
    assign kif.state_dbg     = state_q;

endmodule

// File: tb/tb_aes128_inv_key_expansion.sv
// Directed bench for aes128_inv_key_expansion using FIPS-197 key schedules.
module tb_aes128_inv_key_expansion;
    import aes128_pkg::*;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K5_A   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] K9_A   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K10_B  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_Z  = 128'h0;
    localparam logic [127:0] K10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk_sys;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    aes128_inv_key_expansion_if kif ();

    aes128_inv_key_expansion dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .kif     (kif)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        kif.cipher_key = k;
        kif.key_load   = 1'b1;
        tick(1);
        kif.key_load   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [127:0] key, input logic [3:0] rnd,
                           input logic ready, input logic bsy);
        chk({tag, "_key"}, kif.round_key_out, key);
        chk({tag, "_rnd"}, 128'(kif.round_num_out), 128'(rnd));
        chk({tag, "_rdy"}, 128'(kif.key_ready), 128'(ready));
        chk({tag, "_busy"}, 128'(kif.busy), 128'(bsy));
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        rst_n          = 1'b0;
        kif.key_load   = 1'b0;
        kif.cipher_key = '0;
        kif.rkey_en    = 1'b0;

        // Reset values
        tick(2);
        chk_out("reset", 128'h0, 4'd0, 1'b0, 1'b0);
        chk("reset_state", 128'(kif.state_dbg), 128'(IDLE));
        rst_n = 1'b1;
        tick(1);

        // rkey_en in IDLE is ignored
        kif.rkey_en = 1'b1;
        tick(2);
        kif.rkey_en = 1'b0;
        chk_out("idle_rkey", 128'h0, 4'd0, 1'b0, 1'b0);
        chk("idle_state", 128'(kif.state_dbg), 128'(IDLE));

        // Forward pre-expansion of the FIPS-197 key; cipher_key changed after loading
        load_key(KEY_A);
        kif.cipher_key = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        chk_out("fwd0", KEY_A, 4'd0, 1'b0, 1'b1);
        chk("fwd_state", 128'(kif.state_dbg), 128'(FWD));
        tick(1);
        chk_out("fwd1", K1_A, 4'd1, 1'b0, 1'b1);
        tick(8);
        chk("fwd9_rnd", 128'(kif.round_num_out), 128'd9);
        chk("fwd9_busy", 128'(kif.busy), 128'd1);
        tick(1);
        chk_out("k10_a", K10_A, 4'd10, 1'b1, 1'b0);
        chk("inv_state", 128'(kif.state_dbg), 128'(INV));

        // Step down through the inverse schedule
        kif.rkey_en = 1'b1;
        tick(1);
        kif.rkey_en = 1'b0;
        chk_out("k9_a", K9_A, 4'd9, 1'b1, 1'b0);
        tick(2);
        chk("hold_rnd", 128'(kif.round_num_out), 128'd9);
        kif.rkey_en = 1'b1;
        tick(4);
        chk_out("k5_a", K5_A, 4'd5, 1'b1, 1'b0);
        tick(5);
        chk_out("k0_a", KEY_A, 4'd0, 1'b1, 1'b0);
        tick(1);
        chk_out("k0_extra", KEY_A, 4'd0, 1'b1, 1'b0);
        kif.rkey_en = 1'b0;

        // key_load together with rkey_en, rkey_en held through FWD
        kif.rkey_en = 1'b1;
        load_key(KEY_B);
        chk_out("ld_rk0", KEY_B, 4'd0, 1'b0, 1'b1);
        tick(9);
        chk_out("ld_rk9", kif.round_key_out, 4'd9, 1'b0, 1'b1);
        tick(1);
        kif.rkey_en = 1'b0;
        chk_out("k10_b", K10_B, 4'd10, 1'b1, 1'b0);

        // key_load beats rkey_en while in INV; then restart at FWD cycle 4
        kif.rkey_en = 1'b1;
        load_key(KEY_A);
        kif.rkey_en = 1'b0;
        chk_out("win_ld", KEY_A, 4'd0, 1'b0, 1'b1);
        tick(3);
        chk("pre_restart_rnd", 128'(kif.round_num_out), 128'd3);
        load_key(KEY_Z);
        chk_out("restart0", KEY_Z, 4'd0, 1'b0, 1'b1);
        tick(9);
        chk("restart9_rdy", 128'(kif.key_ready), 128'd0);
        tick(1);
        chk_out("k10_z", K10_Z, 4'd10, 1'b1, 1'b0);

        // Asynchronous reset at round 5 of INV
        kif.rkey_en = 1'b1;
        tick(5);
        kif.rkey_en = 1'b0;
        chk("pre_rst_rnd", 128'(kif.round_num_out), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 128'h0, 4'd0, 1'b0, 1'b0);
        chk("async_rst_state", 128'(kif.state_dbg), 128'(IDLE));
        tick(2);
        rst_n = 1'b1;
        kif.rkey_en = 1'b1;
        tick(3);
        kif.rkey_en = 1'b0;
        chk_out("post_rst", 128'h0, 4'd0, 1'b0, 1'b0);
        chk("post_rst_state", 128'(kif.state_dbg), 128'(IDLE));

        // Reload of the same key after reaching round 0
        load_key(KEY_A);
        tick(10);
        chk_out("c_k10", K10_A, 4'd10, 1'b1, 1'b0);
        kif.rkey_en = 1'b1;
        tick(10);
        kif.rkey_en = 1'b0;
        chk_out("c_k0", KEY_A, 4'd0, 1'b1, 1'b0);
        load_key(KEY_A);
`ifdef AES128_INV_KEY_CACHE_EN
        chk_out("c_hit", K10_A, 4'd10, 1'b1, 1'b0);
        tick(1);
        chk("c_hit_busy", 128'(kif.busy), 128'd0);
`else
        chk_out("c_nohit", KEY_A, 4'd0, 1'b0, 1'b1);
        tick(10);
        chk_out("c_nohit_k10", K10_A, 4'd10, 1'b1, 1'b0);
`endif
        load_key(KEY_B);
        chk_out("c_miss0", KEY_B, 4'd0, 1'b0, 1'b1);
        tick(10);
        chk_out("c_miss10", K10_B, 4'd10, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
